uart_tx_arbiter: RTL and testbench

- Shares the single UART transmit channel (8-bit valid/ready byte input) between NUM_REQ byte-stream requesters, e.g. the CPU memory-mapped store path and a debug/boot message engine.
- Arbitration is round-robin and message-atomic: a winner holds the channel until it sends a byte flagged last.
- A one-entry output register decouples requesters from UART back-pressure.
- Sits between the requesters and the UART DataIn/DataInValid/DataInReady ports.

---
 rtl/uart_tx_arbiter.sv | 94 +++++++++
 tb/tb_uart_tx_arbiter.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin, message-atomic sharing of one UART TX byte channel.
// Optional idle-lock timeout is built only when UART_ARB_TIMEOUT_EN is defined.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [7:0]           uart_data_in,
  output logic                 uart_data_in_valid,
  input  logic                 uart_data_in_ready,
  output logic [1:0]           grant_id,
  output logic                 busy,
  output logic [15:0]          tx_count,
  output logic                 timeout_pulse
);
  if (NUM_REQ < 2 || NUM_REQ > 4 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("uart_tx_arbiter: illegal parameters");
  end
  typedef enum logic {IDLE, LOCK} state_t;
  state_t     state, nextState;
  logic [1:0] lastGrant, winner;
  logic [7:0] outData, grantData;
  logic       outValid, regFree, handshake, transfer, grantValid, grantLast, timeout;
  assign uart_data_in       = outData;
  assign uart_data_in_valid = outValid;
  assign regFree            = ~outValid | uart_data_in_ready;
  assign handshake          = outValid & uart_data_in_ready;
  assign busy               = (state == LOCK) | outValid;
  assign transfer           = (state == LOCK) & grantValid & regFree;
  always_comb begin
    req_ready  = '0;
    grantValid = 1'b0;
    grantLast  = 1'b0;
    grantData  = 8'h00;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_id == 2'(i)) begin
        req_ready[i] = (state == LOCK) & regFree;
        grantValid   = req_valid[i];
        grantLast    = req_last[i];
        grantData    = req_data[8*i +: 8];
      end
    end
  end
  // Scan downwards so the nearest requester after lastGrant is assigned last and wins.
  always_comb begin
    winner = lastGrant;
    for (int k = NUM_REQ; k >= 1; k--) begin
      int idx;
      idx = (int'(lastGrant) + k) % NUM_REQ;
      if (req_valid[idx]) winner = 2'(idx);
    end
  end
  always_comb begin
    nextState = state;
    if (state == IDLE) nextState = |req_valid ? LOCK : IDLE;
    else nextState = ((transfer & grantLast) | timeout) ? IDLE : LOCK;
  end
`ifdef UART_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] idleCnt;
  assign timeout       = (state == LOCK) & (idleCnt == TW'(TIMEOUT_CYCLES));
  assign timeout_pulse = timeout;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) idleCnt <= '0;
    else if (state != LOCK || grantValid || timeout) idleCnt <= '0;
    else idleCnt <= idleCnt + 1'b1;
  end
`else
  assign timeout       = 1'b0;
  assign timeout_pulse = 1'b0;
`endif
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      lastGrant <= 2'(NUM_REQ - 1);
      grant_id  <= 2'd0;
      outValid  <= 1'b0;
      outData   <= 8'h00;
      tx_count  <= 16'h0000;
    end else begin
      state    <= nextState;
      outValid <= transfer | (outValid & ~uart_data_in_ready);
      if (state == IDLE && |req_valid) grant_id <= winner;
      if (transfer) outData <= grantData;
      if ((transfer & grantLast) | timeout) lastGrant <= grant_id;
      if (handshake) tx_count <= tx_count + 16'd1;
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed vector table plus timeout and async-reset sequences.
module tb_uart_tx_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] req_data = '0;
  logic [1:0]  req_valid = '0, req_last = '0, req_ready, grant_id;
  logic [7:0]  uart_data_in;
  logic        uart_data_in_valid, uart_data_in_ready = 1'b1, busy, timeout_pulse;
  logic [15:0] tx_count;
  int nVec = 0, nBad = 0;

  uart_tx_arbiter #(.NUM_REQ(2), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .reset(reset), .req_data(req_data), .req_valid(req_valid),
    .req_last(req_last), .req_ready(req_ready), .uart_data_in(uart_data_in),
    .uart_data_in_valid(uart_data_in_valid), .uart_data_in_ready(uart_data_in_ready),
    .grant_id(grant_id), .busy(busy), .tx_count(tx_count), .timeout_pulse(timeout_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rs;
    logic [1:0] rv, rl;
    logic [7:0] d0, d1;
    logic       ur;
    logic [1:0] rr;
    logic       ov;
    logic [7:0] od;
    logic [1:0] gid;
    logic       bz;
    int         cnt;
  } vec_t;
  vec_t tbl[$];

  function automatic vec_t mk(logic rs, logic [1:0] rv, rl, logic [7:0] d0, d1, logic ur,
                              logic [1:0] rr, logic ov, logic [7:0] od, logic [1:0] gid,
                              logic bz, int cnt);
    vec_t v;
    v.rs = rs; v.rv = rv; v.rl = rl; v.d0 = d0; v.d1 = d1; v.ur = ur;
    v.rr = rr; v.ov = ov; v.od = od; v.gid = gid; v.bz = bz; v.cnt = cnt;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nVec++;
    if (act !== exp) begin
      nBad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial begin
    // reset, single message 41/42/43
    tbl.push_back(mk(1, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h41, 8'h00, 1, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 8'h41, 8'h00, 1, 1, 0, 8'h00, 0, 1, 0));
    tbl.push_back(mk(0, 1, 0, 8'h42, 8'h00, 1, 1, 1, 8'h41, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 8'h43, 8'h00, 1, 1, 1, 8'h42, 0, 1, 1));
    tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 8'h43, 0, 1, 2));
    tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'h43, 0, 0, 3));
    // contention from reset: 0 then 1 then 0 again
    tbl.push_back(mk(1, 3, 0, 8'hA0, 8'hB0, 1, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 3, 0, 8'hA0, 8'hB0, 1, 0, 0, 8'h00, 0, 0, 0));
    tbl.push_back(mk(0, 3, 0, 8'hA0, 8'hB0, 1, 1, 0, 8'h00, 0, 1, 0));
    tbl.push_back(mk(0, 3, 1, 8'hA1, 8'hB0, 1, 1, 1, 8'hA0, 0, 1, 0));
    tbl.push_back(mk(0, 2, 0, 8'h00, 8'hB0, 1, 0, 1, 8'hA1, 0, 1, 1));
    tbl.push_back(mk(0, 2, 0, 8'h00, 8'hB0, 1, 2, 0, 8'hA1, 1, 1, 2));
    tbl.push_back(mk(0, 2, 2, 8'h00, 8'hB1, 1, 2, 1, 8'hB0, 1, 1, 2));
    tbl.push_back(mk(0, 3, 0, 8'hC0, 8'hD0, 1, 0, 1, 8'hB1, 1, 1, 3));
    tbl.push_back(mk(0, 3, 1, 8'hC0, 8'hD0, 1, 1, 0, 8'hB1, 0, 1, 4));
    tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 8'hC0, 0, 1, 4));
    tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'hC0, 0, 0, 5));
    // atomicity with 5 cycles of back-pressure mid-message
    tbl.push_back(mk(0, 1, 0, 8'h10, 8'h00, 1, 0, 0, 8'hC0, 0, 0, 5));
    tbl.push_back(mk(0, 3, 0, 8'h10, 8'hE0, 1, 1, 0, 8'hC0, 0, 1, 5));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 3, 0, 8'h11, 8'hE0, 0, 0, 1, 8'h10, 0, 1, 5));
    tbl.push_back(mk(0, 3, 0, 8'h11, 8'hE0, 1, 1, 1, 8'h10, 0, 1, 5));
    tbl.push_back(mk(0, 3, 1, 8'h12, 8'hE0, 1, 1, 1, 8'h11, 0, 1, 6));
    tbl.push_back(mk(0, 2, 2, 8'h00, 8'hE0, 1, 0, 1, 8'h12, 0, 1, 7));
    tbl.push_back(mk(0, 2, 2, 8'h00, 8'hE0, 1, 2, 0, 8'h12, 1, 1, 8));
    tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 1, 8'hE0, 1, 1, 8));
    tbl.push_back(mk(0, 0, 0, 8'h00, 8'h00, 1, 0, 0, 8'hE0, 1, 0, 9));

    foreach (tbl[n]) begin
      @(negedge clk);
      reset = tbl[n].rs; req_valid = tbl[n].rv; req_last = tbl[n].rl;
      req_data = {tbl[n].d1, tbl[n].d0}; uart_data_in_ready = tbl[n].ur;
      #1;
      chk($sformatf("v%0d req_ready", n), 32'(req_ready), 32'(tbl[n].rr));
      chk($sformatf("v%0d out_valid", n), 32'(uart_data_in_valid), 32'(tbl[n].ov));
      chk($sformatf("v%0d out_data", n), 32'(uart_data_in), 32'(tbl[n].od));
      chk($sformatf("v%0d grant_id", n), 32'(grant_id), 32'(tbl[n].gid));
      chk($sformatf("v%0d busy", n), 32'(busy), 32'(tbl[n].bz));
      chk($sformatf("v%0d tx_count", n), 32'(tx_count), 32'(tbl[n].cnt));
      chk($sformatf("v%0d timeout_pulse", n), 32'(timeout_pulse), 32'h0);
    end

    // requester 0 sends one non-last byte then goes silent while requester 1 waits
    @(negedge clk);
    req_valid = 2'b01; req_last = 2'b00; req_data = {8'h77, 8'h55}; uart_data_in_ready = 1'b1;
    @(negedge clk); #1;
    chk("lock0 req_ready", 32'(req_ready), 32'h1);
    for (int i = 0; i <= 8; i++) begin
      @(negedge clk);
      if (i == 0) req_valid = 2'b10;
      #1;
      if (i == 0) chk("held byte", 32'(uart_data_in), 32'h55);
`ifdef UART_ARB_TIMEOUT_EN
      chk($sformatf("idle%0d timeout_pulse", i), 32'(timeout_pulse), 32'(i == 8));
`else
      chk($sformatf("idle%0d timeout_pulse", i), 32'(timeout_pulse), 32'h0);
`endif
    end
    @(negedge clk); #1;
    chk("after idle tx_count", 32'(tx_count), 32'd10);
    chk("after idle grant_id", 32'(grant_id), 32'h0);
`ifdef UART_ARB_TIMEOUT_EN
    chk("released timeout_pulse", 32'(timeout_pulse), 32'h0);
    chk("released req_ready", 32'(req_ready), 32'h0);
    chk("released busy", 32'(busy), 32'h0);
    @(negedge clk); #1;
    chk("regrant grant_id", 32'(grant_id), 32'h1);
    chk("regrant req_ready", 32'(req_ready), 32'h2);
`else
    chk("held req_ready", 32'(req_ready), 32'h1);
    chk("held busy", 32'(busy), 32'h1);
    @(negedge clk); #1;
    chk("still held grant_id", 32'(grant_id), 32'h0);
    chk("still held req_ready", 32'(req_ready), 32'h1);
`endif

    // async reset while locked with a byte held in the output register
    @(negedge clk);
    req_valid = 2'b11; req_data = {8'h66, 8'h66}; uart_data_in_ready = 1'b1;
    @(negedge clk);
    uart_data_in_ready = 1'b0;
    #1;
    chk("pre-reset out_valid", 32'(uart_data_in_valid), 32'h1);
    chk("pre-reset out_data", 32'(uart_data_in), 32'h66);
    chk("pre-reset busy", 32'(busy), 32'h1);
    #2 reset = 1'b1;
    #1;
    chk("async reset out_valid", 32'(uart_data_in_valid), 32'h0);
    chk("async reset out_data", 32'(uart_data_in), 32'h00);
    chk("async reset busy", 32'(busy), 32'h0);
    chk("async reset tx_count", 32'(tx_count), 32'h0);
    chk("async reset req_ready", 32'(req_ready), 32'h0);
    @(negedge clk);
    reset = 1'b0; req_valid = 2'b00;
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
    $finish;
  end
endmodule
